// File: rtl/svm_sched_pkg.sv
// Shared scheduler definitions: batch FSM state encoding, transaction ID
// width and the default batch geometry used by batch_acceptor.
package svm_sched_pkg;

  localparam int ID_W                = 64;
  localparam int DEFAULT_BATCH_DEPTH = 8;
  localparam int DEFAULT_ACCT_W      = 64;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CHECK   = 2'd1,
    SEAL    = 2'd2
  } batch_state_t;

  // Index width for a table of 'depth' entries, never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/batch_conflict_scan.sv
// Combinational read/write conflict scan of a candidate transaction against
// every valid batch entry, followed by a lowest-index priority encoder.
// Holds no state.
module batch_conflict_scan
  import svm_sched_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_BATCH_DEPTH,
  parameter int ACCT_W = DEFAULT_ACCT_W,
  parameter int IDX_W  = idx_width(DEFAULT_BATCH_DEPTH)
) (
  input  logic [DEPTH-1:0]             entry_valid,
  input  logic [DEPTH-1:0][ACCT_W-1:0] entry_read,
  input  logic [DEPTH-1:0][ACCT_W-1:0] entry_write,
  input  logic [ACCT_W-1:0]            new_read,
  input  logic [ACCT_W-1:0]            new_write,
  output logic                         hit,
  output logic [IDX_W-1:0]             hit_idx
);

  logic [DEPTH-1:0] match;

  // Write-after-read, write-after-write and read-after-write hazards per entry.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = entry_valid[gi] &&
                         ((|(new_write & (entry_read[gi] | entry_write[gi]))) ||
                          (|(new_read & entry_write[gi])));
    end
  endgenerate

  // Lowest-index conflicting entry wins: scan downwards so index 0 is last.
  always_comb begin
    hit     = |match;
    hit_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/batch_acceptor.sv
// Batch acceptor: collects non-conflicting transactions into a batch, rejects
// transactions that clash with entries already held, and hands a sealed batch
// (count plus union read/write masks) downstream with a valid/ready handshake.
// Optional build macro BATCH_TIMEOUT_EN seals a partial batch after
// TIMEOUT_CYCLES idle cycles; without it a batch seals only when full or on
// batch_flush.
module batch_acceptor
  import svm_sched_pkg::*;
#(
  parameter int BATCH_DEPTH    = DEFAULT_BATCH_DEPTH,
  parameter int ACCT_W         = DEFAULT_ACCT_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               transaction_forwarded,
  input  logic [ID_W-1:0]                    owner_programID,
  input  logic [ACCT_W-1:0]                  read_mask,
  input  logic [ACCT_W-1:0]                  write_mask,
  input  logic                               batch_flush,
  output logic                               pipeline_ready,
  output logic [ID_W-1:0]                    accepted_id,
  output logic                               has_conflict,
  output logic [ID_W-1:0]                    conflicting_id,
  output logic                               batch_valid,
  input  logic                               batch_ready,
  output logic [$clog2(BATCH_DEPTH+1)-1:0]   batch_count,
  output logic [ACCT_W-1:0]                  batch_read_mask,
  output logic [ACCT_W-1:0]                  batch_write_mask
);

  localparam int CNT_W = $clog2(BATCH_DEPTH + 1);
  localparam int IDX_W = idx_width(BATCH_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BATCH_DEPTH);

  batch_state_t                       state_reg;
  logic [CNT_W-1:0]                   count_reg;
  logic [BATCH_DEPTH-1:0][ID_W-1:0]   entry_id_reg;
  logic [BATCH_DEPTH-1:0][ACCT_W-1:0] entry_rd_reg;
  logic [BATCH_DEPTH-1:0][ACCT_W-1:0] entry_wr_reg;
  logic [ID_W-1:0]                    cap_id_reg;
  logic [ACCT_W-1:0]                  cap_rd_reg;
  logic [ACCT_W-1:0]                  cap_wr_reg;
  logic                               flush_pending_reg;
  logic [ACCT_W-1:0]                  union_rd_reg;
  logic [ACCT_W-1:0]                  union_wr_reg;
  logic [ID_W-1:0]                    accepted_id_reg;
  logic [ID_W-1:0]                    conflicting_id_reg;
  logic                               has_conflict_reg;
  logic                               batch_valid_reg;
  logic                               ready_reg;

  logic [BATCH_DEPTH-1:0] entry_valid;
  logic                   scan_hit;
  logic [IDX_W-1:0]       scan_idx;
  logic                   accept;
  logic                   timeout_hit;
  logic [CNT_W-1:0]       count_after_check;
  logic                   seal_after_check;

  // Entries below the fill level take part in the conflict scan.
  generate
    for (genvar gi = 0; gi < BATCH_DEPTH; gi++) begin : g_valid
      assign entry_valid[gi] = (CNT_W'(gi) < count_reg);
    end
  endgenerate

  batch_conflict_scan #(
    .DEPTH  (BATCH_DEPTH),
    .ACCT_W (ACCT_W),
    .IDX_W  (IDX_W)
  ) u_scan (
    .entry_valid (entry_valid),
    .entry_read  (entry_rd_reg),
    .entry_write (entry_wr_reg),
    .new_read    (cap_rd_reg),
    .new_write   (cap_wr_reg),
    .hit         (scan_hit),
    .hit_idx     (scan_idx)
  );

  // A pulse is only taken while the acceptor advertises room in COLLECT.
  assign accept = (state_reg == COLLECT) && ready_reg && transaction_forwarded;

  // Decide where CHECK goes: seal when the batch fills, or when a flush was
  // requested during capture/CHECK and the batch ends up non-empty.
  always_comb begin
    count_after_check = scan_hit ? count_reg : (count_reg + CNT_W'(1));
    seal_after_check  = (count_after_check == FULL_CNT) ||
                        ((flush_pending_reg || batch_flush) && (count_after_check != '0));
  end

`ifdef BATCH_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] idle_cnt_reg;
  logic [IDLE_W-1:0] idle_inc;
  logic              idle_cycle;

  assign idle_cycle  = (state_reg == COLLECT) && (count_reg != '0) && !accept;
  assign idle_inc    = idle_cnt_reg + IDLE_W'(1);
  assign timeout_hit = idle_cycle && (idle_inc == IDLE_W'(TIMEOUT_CYCLES));

  // Idle counter: runs while a partial batch waits, restarts on any capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_reg <= '0;
    end else if (idle_cycle && !timeout_hit) begin
      idle_cnt_reg <= idle_inc;
    end else begin
      idle_cnt_reg <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Batch FSM with all batch storage and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= COLLECT;
      count_reg          <= '0;
      entry_id_reg       <= '0;
      entry_rd_reg       <= '0;
      entry_wr_reg       <= '0;
      cap_id_reg         <= '0;
      cap_rd_reg         <= '0;
      cap_wr_reg         <= '0;
      flush_pending_reg  <= 1'b0;
      union_rd_reg       <= '0;
      union_wr_reg       <= '0;
      accepted_id_reg    <= '0;
      conflicting_id_reg <= '0;
      has_conflict_reg   <= 1'b0;
      batch_valid_reg    <= 1'b0;
      ready_reg          <= 1'b0;
    end else begin
      has_conflict_reg <= 1'b0;
      case (state_reg)
        COLLECT: begin
          if (accept) begin
            cap_id_reg        <= owner_programID;
            cap_rd_reg        <= read_mask;
            cap_wr_reg        <= write_mask;
            flush_pending_reg <= batch_flush;
            ready_reg         <= 1'b0;
            state_reg         <= CHECK;
          end else if ((batch_flush && (count_reg != '0)) || timeout_hit) begin
            batch_valid_reg <= 1'b1;
            ready_reg       <= 1'b0;
            state_reg       <= SEAL;
          end else begin
            ready_reg <= (count_reg < FULL_CNT);
          end
        end

        CHECK: begin
          if (scan_hit) begin
            has_conflict_reg   <= 1'b1;
            conflicting_id_reg <= entry_id_reg[scan_idx];
          end else begin
            for (int i = 0; i < BATCH_DEPTH; i++) begin
              if (count_reg == CNT_W'(i)) begin
                entry_id_reg[i] <= cap_id_reg;
                entry_rd_reg[i] <= cap_rd_reg;
                entry_wr_reg[i] <= cap_wr_reg;
              end
            end
            count_reg       <= count_after_check;
            union_rd_reg    <= union_rd_reg | cap_rd_reg;
            union_wr_reg    <= union_wr_reg | cap_wr_reg;
            accepted_id_reg <= cap_id_reg;
          end
          flush_pending_reg <= 1'b0;
          if (seal_after_check) begin
            batch_valid_reg <= 1'b1;
            ready_reg       <= 1'b0;
            state_reg       <= SEAL;
          end else begin
            ready_reg <= 1'b1;
            state_reg <= COLLECT;
          end
        end

        SEAL: begin
          if (batch_ready) begin
            count_reg       <= '0;
            entry_id_reg    <= '0;
            entry_rd_reg    <= '0;
            entry_wr_reg    <= '0;
            union_rd_reg    <= '0;
            union_wr_reg    <= '0;
            batch_valid_reg <= 1'b0;
            ready_reg       <= 1'b1;
            state_reg       <= COLLECT;
          end
        end

        default: begin
          ready_reg <= 1'b0;
          state_reg <= COLLECT;
        end
      endcase
    end
  end

  assign pipeline_ready   = ready_reg;
  assign accepted_id      = accepted_id_reg;
  assign has_conflict     = has_conflict_reg;
  assign conflicting_id   = conflicting_id_reg;
  assign batch_valid      = batch_valid_reg;
  assign batch_count      = count_reg;
  assign batch_read_mask  = union_rd_reg;
  assign batch_write_mask = union_wr_reg;

endmodule

// File: tb/tb_batch_acceptor.sv
// Scenario bench for batch_acceptor: each task drives one scenario and checks
// the DUT against a small reference model and a queue of expected responses.
`timescale 1ns/1ps
module tb_batch_acceptor;

  localparam int DEPTH = 8;
  localparam int AW    = 64;
  localparam int TO    = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          transaction_forwarded = 1'b0;
  logic [63:0]   owner_programID = '0;
  logic [AW-1:0] read_mask = '0;
  logic [AW-1:0] write_mask = '0;
  logic          batch_flush = 1'b0;
  logic          batch_ready = 1'b0;
  logic          pipeline_ready;
  logic [63:0]   accepted_id;
  logic          has_conflict;
  logic [63:0]   conflicting_id;
  logic          batch_valid;
  logic [CW-1:0] batch_count;
  logic [AW-1:0] batch_read_mask;
  logic [AW-1:0] batch_write_mask;

  batch_acceptor #(
    .BATCH_DEPTH    (DEPTH),
    .ACCT_W         (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .transaction_forwarded (transaction_forwarded),
    .owner_programID       (owner_programID),
    .read_mask             (read_mask),
    .write_mask            (write_mask),
    .batch_flush           (batch_flush),
    .pipeline_ready        (pipeline_ready),
    .accepted_id           (accepted_id),
    .has_conflict          (has_conflict),
    .conflicting_id        (conflicting_id),
    .batch_valid           (batch_valid),
    .batch_ready           (batch_ready),
    .batch_count           (batch_count),
    .batch_read_mask       (batch_read_mask),
    .batch_write_mask      (batch_write_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        conflict;
    logic [63:0] id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model of the batch contents.
  logic [63:0] m_id [DEPTH];
  logic [63:0] m_rd [DEPTH];
  logic [63:0] m_wr [DEPTH];
  int          m_n = 0;
  logic [63:0] m_urd = '0;
  logic [63:0] m_uwr = '0;
  logic [63:0] m_acc = '0;
  logic [63:0] m_conf = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_n   = 0;
    m_urd = '0;
    m_uwr = '0;
  endtask

  // One transaction: model predicts, pushes expectation, drives the pulse and
  // pops/compares when the response is due two cycles later.
  task automatic send(input logic [63:0] id, input logic [63:0] r,
                      input logic [63:0] w, input logic flush_in_check);
    exp_t e;
    int   hit;
    hit = -1;
    for (int i = 0; i < m_n; i++) begin
      if (hit < 0 && (((w & (m_rd[i] | m_wr[i])) != 0) || ((r & m_wr[i]) != 0)))
        hit = i;
    end
    if (hit >= 0) begin
      e.conflict = 1'b1;
      e.id       = m_id[hit];
    end else begin
      e.conflict  = 1'b0;
      e.id        = id;
      m_id[m_n]   = id;
      m_rd[m_n]   = r;
      m_wr[m_n]   = w;
      m_n         = m_n + 1;
      m_urd       = m_urd | r;
      m_uwr       = m_uwr | w;
    end
    sb.push_back(e);

    transaction_forwarded = 1'b1;
    owner_programID       = id;
    read_mask             = r;
    write_mask            = w;
    tick();
    transaction_forwarded = 1'b0;
    if (flush_in_check) batch_flush = 1'b1;
    checks++; if (pipeline_ready !== 1'b0) begin errors++; $display("FAIL ready_in_check id=%h: got %b expected 0", id, pipeline_ready); end
    checks++; if (has_conflict !== 1'b0) begin errors++; $display("FAIL early_conflict id=%h: got %b expected 0", id, has_conflict); end
    checks++; if (accepted_id !== m_acc) begin errors++; $display("FAIL early_accept id=%h: got %h expected %h", id, accepted_id, m_acc); end
    tick();
    batch_flush = 1'b0;

    e = sb.pop_front();
    if (e.conflict) m_conf = e.id;
    else            m_acc  = e.id;
    checks++; if (has_conflict !== e.conflict) begin errors++; $display("FAIL has_conflict id=%h: got %b expected %b", id, has_conflict, e.conflict); end
    checks++; if (conflicting_id !== m_conf) begin errors++; $display("FAIL conflicting_id id=%h: got %h expected %h", id, conflicting_id, m_conf); end
    checks++; if (accepted_id !== m_acc) begin errors++; $display("FAIL accepted_id id=%h: got %h expected %h", id, accepted_id, m_acc); end
    checks++; if (batch_count !== CW'(m_n)) begin errors++; $display("FAIL batch_count id=%h: got %0d expected %0d", id, batch_count, m_n); end
    $display("txn id=%h r=%h w=%h -> conflict=%0b ref_id=%h count=%0d", id, r, w, has_conflict, e.conflict ? conflicting_id : accepted_id, batch_count);
    tick();
    checks++; if (has_conflict !== 1'b0) begin errors++; $display("FAIL conflict_pulse_width id=%h: got %b expected 0", id, has_conflict); end
  endtask

  task automatic test_drain();
    batch_ready = 1'b1;
    tick();
    batch_ready = 1'b0;
    model_clear();
    checks++; if (batch_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b expected 0", batch_valid); end
    checks++; if (batch_count !== '0) begin errors++; $display("FAIL drain_count: got %0d expected 0", batch_count); end
    checks++; if (batch_read_mask !== '0 || batch_write_mask !== '0) begin errors++; $display("FAIL drain_masks: got %h/%h expected 0/0", batch_read_mask, batch_write_mask); end
    checks++; if (pipeline_ready !== 1'b1) begin errors++; $display("FAIL drain_ready: got %b expected 1", pipeline_ready); end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (pipeline_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", pipeline_ready); end
    checks++; if (batch_valid !== 1'b0 || has_conflict !== 1'b0) begin errors++; $display("FAIL reset_flags: got valid=%b conflict=%b expected 0/0", batch_valid, has_conflict); end
    checks++; if (accepted_id !== '0 || conflicting_id !== '0) begin errors++; $display("FAIL reset_ids: got %h/%h expected 0/0", accepted_id, conflicting_id); end
    checks++; if (batch_count !== '0 || batch_read_mask !== '0 || batch_write_mask !== '0) begin errors++; $display("FAIL reset_batch: got count=%0d masks=%h/%h expected 0", batch_count, batch_read_mask, batch_write_mask); end
    rst_n = 1'b1;
    tick();
    checks++; if (pipeline_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", pipeline_ready); end
  endtask

  task automatic test_accept_conflict();
    send(64'h11, 64'h1, 64'h2, 1'b0);
    send(64'h22, 64'h2, 64'h0, 1'b0);
    checks++; if (pipeline_ready !== 1'b1) begin errors++; $display("FAIL ready_after_conflict: got %b expected 1", pipeline_ready); end
  endtask

  task automatic test_flush();
    int seen;
    send(64'h33, 64'h10, 64'h20, 1'b0);
    send(64'h44, 64'h40, 64'h80, 1'b0);
    batch_flush = 1'b1;
    tick();
    batch_flush = 1'b0;
    checks++; if (batch_valid !== 1'b1) begin errors++; $display("FAIL flush_valid: got %b expected 1", batch_valid); end
    checks++; if (batch_count !== CW'(3)) begin errors++; $display("FAIL flush_count: got %0d expected 3", batch_count); end
    checks++; if (batch_read_mask !== 64'h51 || batch_write_mask !== 64'hA2) begin errors++; $display("FAIL flush_masks: got %h/%h expected 51/a2", batch_read_mask, batch_write_mask); end
    checks++; if (pipeline_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", pipeline_ready); end
    test_drain();
    batch_flush = 1'b1;
    tick();
    batch_flush = 1'b0;
    seen = (batch_valid !== 1'b0) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (batch_valid !== 1'b0) seen = 1;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL empty_flush: got batch_valid=1 expected 0"); end
  endtask

  task automatic test_fill();
    int bad;
    for (int i = 0; i < DEPTH; i++)
      send(64'h100 + 64'(i), 64'h1 << (2 * i), 64'h1 << (2 * i + 1), 1'b0);
    checks++; if (pipeline_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", pipeline_ready); end
    checks++; if (batch_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b expected 1", batch_valid); end
    checks++; if (batch_count !== CW'(8)) begin errors++; $display("FAIL full_count: got %0d expected 8", batch_count); end
    checks++; if (batch_read_mask !== 64'h5555 || batch_write_mask !== 64'hAAAA) begin errors++; $display("FAIL full_masks: got %h/%h expected 5555/aaaa", batch_read_mask, batch_write_mask); end
    // Hold batch_ready low; a stray pulse while sealed must be ignored.
    bad = 0;
    transaction_forwarded = 1'b1;
    owner_programID       = 64'hDEAD;
    read_mask             = 64'h1;
    write_mask            = 64'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      transaction_forwarded = 1'b0;
      if (batch_valid !== 1'b1 || batch_count !== CW'(8) || pipeline_ready !== 1'b0 ||
          batch_read_mask !== 64'h5555 || batch_write_mask !== 64'hAAAA || has_conflict !== 1'b0)
        bad = 1;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL seal_stable: got change while batch_ready=0 expected stable"); end
    checks++; if (accepted_id !== 64'h107) begin errors++; $display("FAIL pulse_in_seal: got accepted_id %h expected 107", accepted_id); end
    test_drain();
  endtask

  task automatic test_flush_in_check();
    send(64'h77, 64'h100, 64'h200, 1'b1);
    checks++; if (batch_valid !== 1'b1 || batch_count !== CW'(1)) begin errors++; $display("FAIL flush_in_check: got valid=%b count=%0d expected 1/1", batch_valid, batch_count); end
    test_drain();
  endtask

  task automatic test_timeout();
    int early;
    send(64'h88, 64'h400, 64'h800, 1'b0);
    early = 0;
`ifdef BATCH_TIMEOUT_EN
    for (int i = 0; i < TO - 2; i++) begin
      tick();
      if (batch_valid !== 1'b0) early = 1;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL timeout_early: got batch_valid=1 before %0d idle cycles expected 0", TO); end
    tick();
    checks++; if (batch_valid !== 1'b1 || batch_count !== CW'(1)) begin errors++; $display("FAIL timeout_seal: got valid=%b count=%0d expected 1/1", batch_valid, batch_count); end
    test_drain();
`else
    for (int i = 0; i < 3 * TO; i++) begin
      tick();
      if (batch_valid !== 1'b0) early = 1;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL no_timeout: got batch_valid=1 expected 0"); end
    batch_flush = 1'b1;
    tick();
    batch_flush = 1'b0;
    test_drain();
`endif
  endtask

  task automatic test_reset_mid_check();
    int seen;
    send(64'h55, 64'h1000, 64'h2000, 1'b0);
    transaction_forwarded = 1'b1;
    owner_programID       = 64'h66;
    read_mask             = 64'h2000;
    write_mask            = 64'h0;
    tick();
    transaction_forwarded = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (has_conflict !== 1'b0 || accepted_id !== '0 || batch_count !== '0) begin errors++; $display("FAIL async_reset: got conflict=%b acc=%h count=%0d expected 0", has_conflict, accepted_id, batch_count); end
    tick();
    tick();
    rst_n = 1'b1;
    sb.delete();
    model_clear();
    m_acc  = '0;
    m_conf = '0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (has_conflict !== 1'b0) seen = 1;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abandoned_conflict: got has_conflict=1 expected 0"); end
    checks++; if (accepted_id !== '0 || conflicting_id !== '0) begin errors++; $display("FAIL abandoned_ids: got %h/%h expected 0/0", accepted_id, conflicting_id); end
    checks++; if (batch_count !== '0 || pipeline_ready !== 1'b1) begin errors++; $display("FAIL abandoned_batch: got count=%0d ready=%b expected 0/1", batch_count, pipeline_ready); end
  endtask

  initial begin
    test_reset();
    test_accept_conflict();
    test_flush();
    test_fill();
    test_flush_in_check();
    test_timeout();
    test_reset_mid_check();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 ns expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/batch_acceptor.md
BATCH_ACCEPTOR -- requirements
Module: batch_acceptor

Interface
REQ-001 SHALL have parameter BATCH_DEPTH, default 8, meaning the maximum number of transactions held in one batch.
REQ-002 SHALL have parameter ACCT_W, default 64, meaning the width of the account read/write masks.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning the idle cycles before a partial batch seals (only with BATCH_TIMEOUT_EN).
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk, input, 1, the system clock.
REQ-006 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-007 SHALL have port transaction_forwarded, input, 1, a one-cycle pulse marking a new transaction.
REQ-008 SHALL have port owner_programID, input, 64, the incoming transaction ID.
REQ-009 SHALL have ports read_mask and write_mask, input, ACCT_W each, the incoming dependency masks.
REQ-010 SHALL have port batch_flush, input, 1, a request to seal a non-empty batch.
REQ-011 SHALL have port pipeline_ready, output, 1, meaning the acceptor can take a transaction.
REQ-012 SHALL have port accepted_id, output, 64, the ID of the last accepted transaction.
REQ-013 SHALL have port has_conflict, output, 1, a one-cycle pulse marking a rejected transaction.
REQ-014 SHALL have port conflicting_id, output, 64, the ID of the batch entry that caused the rejection.
REQ-015 SHALL have ports batch_valid (output, 1) and batch_ready (input, 1), the downstream handshake.
REQ-016 SHALL have port batch_count, output, $clog2(BATCH_DEPTH+1), the number of entries in the sealed batch.
REQ-017 SHALL have ports batch_read_mask and batch_write_mask, output, ACCT_W each, the union masks of the sealed batch.

Function
REQ-018 SHALL implement an FSM with states COLLECT, CHECK, SEAL.
REQ-019 In COLLECT, pipeline_ready SHALL be 1 when count<BATCH_DEPTH; in all other states or when full it SHALL be 0.
REQ-020 On transaction_forwarded in COLLECT, the block SHALL capture ID and masks and go to CHECK; the pulse SHALL be ignored in any other state.
REQ-021 CHECK: an entry conflicts if (new write & (entry read|entry write)) != 0 or (new read & entry write) != 0.
REQ-022 Leaving CHECK (one cycle after capture), on conflict: has_conflict pulses one cycle, conflicting_id is set to the lowest-index conflicting entry's ID, the batch is unchanged.
REQ-023 Leaving CHECK with no conflict: the entry is appended, count increments, union masks OR in the new masks, and accepted_id is updated the same cycle and held.
REQ-024 Response latency SHALL be exactly 2 cycles from the transaction_forwarded edge to the accepted_id update or has_conflict pulse.
REQ-025 From CHECK, the block SHALL go to SEAL if count reaches BATCH_DEPTH, otherwise to COLLECT.
REQ-026 batch_flush SHALL seal from COLLECT when count>0; batch_flush with count==0 SHALL be ignored; batch_flush during CHECK SHALL be applied after CHECK completes.
REQ-027 In SEAL, batch_valid SHALL be 1 with batch_count and the union masks stable; on batch_valid&&batch_ready, the block SHALL clear entries, count and masks and return to COLLECT the next cycle.
REQ-028 conflicting_id SHALL hold its value between conflicts.

Reset
REQ-029 On reset: state=COLLECT, count=0, masks=0, pipeline_ready=0 during reset and 1 on the first cycle after reset, accepted_id=0, conflicting_id=0, has_conflict=0, batch_valid=0.
REQ-030 A reset asserted mid-CHECK or mid-SEAL SHALL abandon the transaction or batch with no response.

Configuration
REQ-031 With BATCH_TIMEOUT_EN defined: an idle counter SHALL count cycles in COLLECT with count>0 and no capture, SHALL reset on each capture, and when it equals TIMEOUT_CYCLES the block SHALL seal.
REQ-032 Without BATCH_TIMEOUT_EN, the block SHALL seal only when full or on batch_flush, and SHALL contain no timeout counter.

Structure
REQ-033 Package svm_sched_pkg SHALL hold the FSM state encoding, the 64-bit ID width constant and the default BATCH_DEPTH and ACCT_W.
REQ-034 Sub-module batch_conflict_scan SHALL hold the combinational per-entry mask compare and the lowest-index priority encoder; all state SHALL remain in batch_acceptor.

Verification
REQ-035 Forward ID 0x11 (R=0x1, W=0x2) into an empty batch -> two cycles later accepted_id=0x11 and count=1.
REQ-036 Then forward ID 0x22 (R=0x2, W=0x0) -> has_conflict pulses one cycle, conflicting_id=0x11, count stays 1.
REQ-037 Fill 8 disjoint transactions -> pipeline_ready=0, batch_valid=1, batch_count=8, union masks correct; hold batch_ready=0 for 5 cycles -> outputs stable; assert batch_ready -> next cycle empty and pipeline_ready=1.
REQ-038 Assert batch_flush with count=3 -> batch_count=3 sealed; batch_flush with count=0 -> no batch_valid.
REQ-039 With BATCH_TIMEOUT_EN and TIMEOUT_CYCLES=16: 1 entry then idle -> batch_valid after exactly 16 idle cycles; without the macro -> never.
REQ-040 Assert rst_n low during CHECK -> no has_conflict, accepted_id=0, count=0 after release.
